// File: rtl/pc_gen.sv
// pc_gen -- program counter generator with an optional return-address stack.
//
// Next-PC selection, highest priority first:
//   start_i low (hold) > redirect_i > stall_i (hold) > branch_i > jump_i > pc_o + INC
// All PC arithmetic wraps modulo 2^WIDTH.
//
// Optional feature: define PC_GEN_RAS_EN to build the return-address stack
// (RAS).
//   - A jump qualified by call_i pushes pc_o + INC.
//   - A jump qualified by ret_i pops the stack and uses the top as its target.
//   - When the macro is undefined, call_i/ret_i are ignored, a jump always
//     loads jump_pc_i, ras_empty_o is tied to 1 and ras_full_o is tied to 0.
//
// Ports
//   clk_i          clock, rising-edge active
//   rst_i          asynchronous active-low reset
//   start_i        run enable; low holds the PC and clears valid_o
//   stall_i        holds the PC and the RAS (redirect still wins)
//   redirect_i     flush/exception redirect to redirect_pc_i
//   branch_i       taken branch to branch_pc_i
//   jump_i         jump to jump_pc_i (or to the RAS top on a return)
//   call_i, ret_i  qualify jump_i as call / return
//   pc_o           registered current PC
//   pc_next_o      combinational value pc_o takes at the next edge
//   valid_o        registered; high when pc_o is fetchable
//   ras_empty_o    RAS occupancy flag: stack is empty
//   ras_full_o     RAS occupancy flag: stack is full
module pc_gen #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter int unsigned       INC       = 4,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] branch_pc_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_pc_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_next_o,
  output logic             valid_o,
  output logic             ras_empty_o,
  output logic             ras_full_o
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] jump_tgt;
  logic             take_jump;

  assign pc_inc = pc_q + WIDTH'(INC);

  // A jump only takes effect when nothing of higher priority claims the cycle;
  // the RAS is touched only under the same condition.
  assign take_jump = start_i & ~redirect_i & ~stall_i & ~branch_i & jump_i;

`ifdef PC_GEN_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Circular stack: sp_q points at the next free slot, the top is sp_q-1.
  // Pushing while full simply advances sp_q, overwriting the oldest entry.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ras_we;
  logic [PTR_W-1:0] ras_wr_idx;
  logic [PTR_W-1:0] top_idx;
  logic             ras_empty, ras_full;
  logic             do_push, do_pop;

  assign top_idx   = sp_q - PTR_W'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign do_push   = take_jump & call_i;
  assign do_pop    = take_jump & ret_i & ~ras_empty;
  assign jump_tgt  = do_pop ? ras_mem[top_idx] : jump_pc_i;

  always_comb begin
    sp_d       = sp_q;
    cnt_d      = cnt_q;
    ras_we     = 1'b0;
    ras_wr_idx = sp_q;
    if (do_push && do_pop) begin
      // Pop then push collapses to replacing the top in place.
      ras_we     = 1'b1;
      ras_wr_idx = top_idx;
    end else if (do_push) begin
      ras_we = 1'b1;
      sp_d   = sp_q + PTR_W'(1);
      if (!ras_full) cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop) begin
      sp_d  = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk_i) begin
    if (ras_we) ras_mem[ras_wr_idx] <= pc_inc;
  end

  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = call_i ^ ret_i ^ take_jump;
  assign jump_tgt    = jump_pc_i;
  assign ras_empty_o = 1'b1;
  assign ras_full_o  = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_q;
    valid_d = start_i;
    if (!start_i)        pc_d = pc_q;
    else if (redirect_i) pc_d = redirect_pc_i;
    else if (stall_i)    pc_d = pc_q;
    else if (branch_i)   pc_d = branch_pc_i;
    else if (jump_i)     pc_d = jump_tgt;
    else                 pc_d = pc_inc;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;
  assign valid_o   = valid_q;

endmodule
